// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: default parameters and address-width helper shared by the register bank
package reg_bank_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_BYPASS  = 1;
    localparam int DEF_ZERO_R0 = 0;

    function automatic int aw_f(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/reg_bank_entry.sv
// reg_bank_entry: one live/shadow register pair with its dirty flag
module reg_bank_entry #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              save_i,
    input  logic              restore_i,
    output logic [DATA_W-1:0] live_o,
    output logic              dirty_o
);

    logic [DATA_W-1:0] live_d, live_q;
    logic [DATA_W-1:0] shadow_d, shadow_q;
    logic              dirty_d, dirty_q;

    // restore outranks write; save samples the pre-edge live value, so save+restore swaps
    always_comb begin
        live_d   = restore_i ? shadow_q : (we_i ? wdata_i : live_q);
        shadow_d = save_i ? live_q : shadow_q;
        dirty_d  = (save_i || restore_i) ? (we_i && !restore_i) : (dirty_q || we_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q   <= '0;
            shadow_q <= '0;
            dirty_q  <= 1'b0;
        end else begin
            live_q   <= live_d;
            shadow_q <= shadow_d;
            dirty_q  <= dirty_d;
        end
    end

    assign live_o  = live_q;
    assign dirty_o = dirty_q;

endmodule

// File: rtl/reg_bank.sv
// reg_bank: two-read/one-write register file with shadow bank save/restore/swap and dirty tracking
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int BYPASS  = DEF_BYPASS,
    parameter int ZERO_R0 = DEF_ZERO_R0,
    localparam int AW     = aw_f(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_a_i,
    input  logic [AW-1:0]     raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic              save_i,
    input  logic              restore_i,
    output logic [DEPTH-1:0]  dirty_o
);

    logic [DATA_W-1:0] live [DEPTH];
    logic [DEPTH-1:0]  we_e;
    logic              wr_req;
    logic              wr_hit;
    logic              byp_a, byp_b;
    logic [DATA_W-1:0] rd_a, rd_b;

    assign wr_req = we_i && !restore_i;

    // out-of-range addresses match no entry, so they never write, dirty or bypass
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign we_e[i] = wr_req && (waddr_i == AW'(i)) && !((ZERO_R0 != 0) && (i == 0));
        reg_bank_entry #(
            .DATA_W(DATA_W)
        ) u_entry (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .we_i     (we_e[i]),
            .wdata_i  (wdata_i),
            .save_i   (save_i),
            .restore_i(restore_i),
            .live_o   (live[i]),
            .dirty_o  (dirty_o[i])
        );
    end

    assign wr_hit = |we_e;
    assign byp_a  = (BYPASS != 0) && wr_hit && (raddr_a_i == waddr_i);
    assign byp_b  = (BYPASS != 0) && wr_hit && (raddr_b_i == waddr_i);

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_a_i == AW'(i) && !((ZERO_R0 != 0) && (i == 0))) rd_a = live[i];
            if (raddr_b_i == AW'(i) && !((ZERO_R0 != 0) && (i == 0))) rd_b = live[i];
        end
        rdata_a_o = byp_a ? wdata_i : rd_a;
        rdata_b_o = byp_b ? wdata_i : rd_b;
    end

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed checks of three reg_bank configurations driven by shared inputs
module tb_reg_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we = 1'b0, save = 1'b0, restore = 1'b0;
    logic [1:0] waddr = '0, raddr_a = '0, raddr_b = '0;
    logic [7:0] wdata = '0;

    logic [7:0] a_rda, a_rdb, b_rda, b_rdb, c_rda, c_rdb;
    logic [3:0] a_dirty, b_dirty;
    logic [2:0] c_dirty;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_bank u_a (
        .clk_i(clk), .rst_ni(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .rdata_a_o(a_rda), .rdata_b_o(a_rdb),
        .save_i(save), .restore_i(restore), .dirty_o(a_dirty)
    );

    reg_bank #(.BYPASS(0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .rdata_a_o(b_rda), .rdata_b_o(b_rdb),
        .save_i(save), .restore_i(restore), .dirty_o(b_dirty)
    );

    reg_bank #(.DEPTH(3), .ZERO_R0(1)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .rdata_a_o(c_rda), .rdata_b_o(c_rdb),
        .save_i(save), .restore_i(restore), .dirty_o(c_dirty)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] data);
        we = 1'b1;
        waddr = addr;
        wdata = data;
        tick();
        we = 1'b0;
    endtask

    task automatic pulse_save();
        save = 1'b1;
        tick();
        save = 1'b0;
    endtask

    task automatic pulse_restore();
        restore = 1'b1;
        tick();
        restore = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #3;
        chk("reset_dirty_a", a_dirty, 4'b0000);
        chk("reset_rd_a", a_rda, 8'h00);
        #4 rst_n = 1'b1;
        tick();

        // basic write then two-port read
        wr(2'd2, 8'hA5);
        raddr_a = 2'd2;
        raddr_b = 2'd0;
        #1;
        chk("basic_rd_a", a_rda, 8'hA5);
        chk("basic_rd_b", a_rdb, 8'h00);
        chk("basic_dirty_a", a_dirty, 4'b0100);
        chk("basic_dirty_c", c_dirty, 3'b100);

        // bypass vs no bypass
        wr(2'd1, 8'h11);
        we = 1'b1; waddr = 2'd1; wdata = 8'h22;
        raddr_a = 2'd1; raddr_b = 2'd1;
        #1;
        chk("byp_a_port_a", a_rda, 8'h22);
        chk("byp_a_port_b", a_rdb, 8'h22);
        chk("nobyp_port_a", b_rda, 8'h11);
        chk("nobyp_port_b", b_rdb, 8'h11);
        tick();
        we = 1'b0;
        #1;
        chk("nobyp_next_a", b_rda, 8'h22);
        chk("byp_dirty_a", a_dirty, 4'b0110);

        // save with a same-cycle write
        wr(2'd0, 8'h01);
        wr(2'd1, 8'h02);
        wr(2'd2, 8'h03);
        wr(2'd3, 8'h04);
        chk("fill_dirty_a", a_dirty, 4'b1111);
        save = 1'b1; we = 1'b1; waddr = 2'd3; wdata = 8'hFF;
        tick();
        save = 1'b0; we = 1'b0;
        raddr_a = 2'd3;
        #1;
        chk("savewr_live_r3", a_rda, 8'hFF);
        chk("savewr_dirty_a", a_dirty, 4'b1000);
        chk("savewr_dirty_c", c_dirty, 3'b000);
        pulse_restore();
        chk("restore_live_r3", a_rda, 8'h04);
        chk("restore_dirty_a", a_dirty, 4'b0000);
        raddr_a = 2'd0;
        #1;
        chk("restore_live_r0", a_rda, 8'h01);

        // restore beats a same-cycle write
        wr(2'd2, 8'h09);
        pulse_save();
        chk("save_clears_dirty", a_dirty, 4'b0000);
        wr(2'd2, 8'h33);
        chk("prio_pre_dirty", a_dirty, 4'b0100);
        restore = 1'b1; we = 1'b1; waddr = 2'd2; wdata = 8'h77; raddr_a = 2'd2;
        #1;
        chk("prio_no_bypass", a_rda, 8'h33);
        tick();
        restore = 1'b0; we = 1'b0;
        #1;
        chk("prio_live_r2", a_rda, 8'h09);
        chk("prio_dirty_a", a_dirty, 4'b0000);

        // atomic swap
        wr(2'd0, 8'h20);
        pulse_save();
        wr(2'd0, 8'h10);
        raddr_a = 2'd0;
        save = 1'b1; restore = 1'b1;
        tick();
        save = 1'b0; restore = 1'b0;
        #1;
        chk("swap_live_r0", a_rda, 8'h20);
        chk("swap_dirty_a", a_dirty, 4'b0000);
        pulse_restore();
        chk("swap_shadow_r0", a_rda, 8'h10);

        // zero register and out-of-range address
        we = 1'b1; waddr = 2'd0; wdata = 8'h55; raddr_a = 2'd0;
        #1;
        chk("zero_r0_no_bypass", c_rda, 8'h00);
        tick();
        we = 1'b0;
        #1;
        chk("zero_r0_read", c_rda, 8'h00);
        chk("zero_r0_dirty", c_dirty, 3'b000);
        chk("plain_r0_read", a_rda, 8'h55);
        we = 1'b1; waddr = 2'd3; wdata = 8'h66; raddr_b = 2'd3;
        #1;
        chk("oor_no_bypass", c_rdb, 8'h00);
        tick();
        we = 1'b0;
        #1;
        chk("oor_read", c_rdb, 8'h00);
        chk("oor_dirty_c", c_dirty, 3'b000);
        chk("inrange_dirty_a", a_dirty, 4'b1001);
        chk("inrange_read_a", a_rdb, 8'h66);

        // asynchronous reset mid-clock during a save
        wr(2'd1, 8'h5A);
        pulse_save();
        wr(2'd1, 8'h6B);
        raddr_a = 2'd1;
        save = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_live_r1", a_rda, 8'h00);
        chk("arst_dirty_a", a_dirty, 4'b0000);
        save = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        pulse_restore();
        chk("arst_shadow_r1", a_rda, 8'h00);
        wr(2'd2, 8'hC3);
        raddr_a = 2'd2;
        #1;
        chk("post_rst_write", a_rda, 8'hC3);
        chk("post_rst_dirty", a_dirty, 4'b0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each register in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of registers, from 2 to 256.
REQ-003 SHALL have parameter BYPASS, default 1; when 1, a read of the register being written returns the write data in the same cycle.
REQ-004 SHALL have parameter ZERO_R0, default 0; when 1, register 0 always reads 0 and ignores writes.
REQ-005 SHALL derive localparam AW = max(1, $clog2(DEPTH)) for all address ports.
REQ-006 SHALL have port clk_i, input, 1 bit, sole clock; all state changes on the rising edge.
REQ-007 SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port we_i, input, 1 bit, write enable.
REQ-009 SHALL have port waddr_i, input, AW bits, write address.
REQ-010 SHALL have port wdata_i, input, DATA_W bits, write data.
REQ-011 SHALL have ports raddr_a_i and raddr_b_i, inputs, AW bits each, read addresses.
REQ-012 SHALL have ports rdata_a_o and rdata_b_o, outputs, DATA_W bits each, read data.
REQ-013 SHALL have port save_i, input, 1 bit, copy all live registers to the shadow bank.
REQ-014 SHALL have port restore_i, input, 1 bit, copy the shadow bank to the live registers.
REQ-015 SHALL have port dirty_o, output, DEPTH bits, per-register flag: written since the last save or restore.

Function
REQ-016 Writes SHALL be synchronous: when we_i=1, live[waddr_i] <= wdata_i at the next edge.
REQ-017 Reads SHALL be combinational from live registers, with zero latency.
REQ-018 With BYPASS=1, if we_i=1 and a read address equals waddr_i, that port SHALL output wdata_i; with BYPASS=0 it SHALL output the old value.
REQ-019 A write with waddr_i >= DEPTH SHALL be ignored, and a read with an address >= DEPTH SHALL return 0.
REQ-020 With ZERO_R0=1, a write to address 0 SHALL be dropped, set no dirty bit and never bypass.
REQ-021 save_i=1 SHALL copy every live register to shadow in one cycle, capturing values from before any same-cycle write.
REQ-022 restore_i=1 SHALL copy every shadow register to live in one cycle.
REQ-023 Priority SHALL be restore over write: when restore_i=1, a same-cycle we_i is dropped, with no write and no dirty update.
REQ-024 While restore_i=1, bypass SHALL be suppressed and reads SHALL return the pre-edge live values.
REQ-025 save_i=1 together with restore_i=1 SHALL swap the live and shadow banks atomically.
REQ-026 A successful write SHALL set dirty_o[waddr_i].
REQ-027 save or restore SHALL clear all dirty bits, except that save with a same-cycle successful write leaves only that register's bit set.
REQ-028 dirty_o SHALL be a registered output.

Reset
REQ-029 When rst_ni is asserted low, all live registers, all shadow registers and dirty_o SHALL clear to 0 immediately, regardless of clk_i.
REQ-030 Reset assertion SHALL abort any in-flight write, save or restore; no partial copy may remain after release.
REQ-031 Release of rst_ni SHALL be synchronised by the integrator, and the block SHALL accept operations on the first edge after release.

Structure
REQ-032 The shared package reg_bank_pkg SHALL hold the default values of DATA_W, DEPTH, BYPASS and ZERO_R0, plus the AW derivation function.
REQ-033 Each entry SHALL be implemented as sub-module reg_bank_entry (live, shadow and dirty flip-flops plus per-entry write/save/restore muxing), instantiated DEPTH times with a generate loop.
REQ-034 Read muxes, bypass and address decode SHALL live in reg_bank; the block SHALL contain no latches.

Verification
REQ-035 Reset then basic write: reset, write 0xA5 to r2, then read r2 on port A and r0 on port B -> rdata_a_o=0xA5, rdata_b_o=0x00, dirty_o=0b0100.
REQ-036 Bypass: BYPASS=1, r1=0x11, write 0x22 to r1 while both ports read r1 -> both ports show 0x22 in the same cycle; with BYPASS=0 -> 0x11, then 0x22 next cycle.
REQ-037 Save with write: live = {0x01, 0x02, 0x03, 0x04}, save_i together with a write of 0xFF to r3 -> shadow r3 = 0x04, live r3 = 0xFF, dirty_o = 0b1000; restore next cycle -> live r3 = 0x04, dirty_o = 0.
REQ-038 Swap: live r0 = 0x10, shadow r0 = 0x20, save_i and restore_i together -> live r0 = 0x20, shadow r0 = 0x10.
REQ-039 Restore priority: restore_i together with a write of 0x77 to r2, shadow r2 = 0x09 -> live r2 = 0x09, dirty_o[2] = 0.
REQ-040 Boundaries: ZERO_R0=1, write 0x55 to r0 -> reads 0; DEPTH=3, write to address 3 ignored and read of address 3 = 0; rst_ni pulsed low mid-clock during a save -> all state is 0 without waiting for an edge.
